// File: rtl/dll_tx_seq_package.sv
// Shared types for the DLL TX TLP sequencer: FIFO entry layout and FSM state encoding.
package dll_tx_seq_package;

    localparam int SEQ_W      = 12;
    localparam int ENT_DATA_W = 256;
    localparam int ENT_VDW_W  = 3;

    typedef struct packed {
        logic                  sop;
        logic                  eop;
        logic                  err;
        logic [ENT_VDW_W-1:0]  vdw;
        logic [SEQ_W-1:0]      seq;
        logic [ENT_DATA_W-1:0] data;
    } seq_entry_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_IN_TLP = 1'b1
    } seq_state_t;

endpackage

// File: rtl/dll_tx_seq_fifo.sv
// First-word-fall-through FIFO of sequencer entries; head reads as zero while empty.
module dll_tx_seq_fifo
    import dll_tx_seq_package::*;
#(
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
)(
    input  logic             clk,
    input  logic             arst,
    input  logic             wr,
    input  seq_entry_t       wr_ent,
    input  logic             rd,
    output seq_entry_t       head,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] free,
    output logic             full
);

    seq_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             rd_ok;
    logic             wr_ok;

    assign rd_ok = rd & (count_q != '0);
    assign wr_ok = wr & (~full | rd_ok);

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (rd_ok) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset; the empty gate below keeps stale entries off the outputs.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr_q] <= wr_ent;
    end

    assign head  = (count_q == '0) ? '0 : mem[rd_ptr_q];
    assign count = count_q;
    assign free  = CNT_W'(DEPTH) - count_q;
    assign full  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/dll_tx_tlp_sequencer.sv
// TL/DLL boundary: stamps TLPs with sequence numbers, buffers beats, drives Frag halts.
// Optional length check enabled by defining DLL_TX_LEN_CHECK_EN.
//
// state     | meaning
// ST_IDLE   | between TLPs, only a sop beat is legal
// ST_IN_TLP | inside a TLP, waiting for eop
module dll_tx_tlp_sequencer
    import dll_tx_seq_package::*;
#(
    parameter int DATA_W   = ENT_DATA_W,
    parameter int VDW_W    = ENT_VDW_W,
    parameter int LEN_W    = 11,
    parameter int DEPTH    = 8,
    parameter int HALT1_TH = 4,
    parameter int HALT2_TH = 2
)(
    input  logic              clk,
    input  logic              arst,
    input  logic              in_valid,
    input  logic              in_sop,
    input  logic              in_eop,
    input  logic [LEN_W-1:0]  in_len,
    input  logic [VDW_W-1:0]  in_vdw,
    input  logic [DATA_W-1:0] in_data,
    output logic              halt_1,
    output logic              halt_2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sop,
    output logic              out_eop,
    output logic [VDW_W-1:0]  out_vdw,
    output logic [DATA_W-1:0] out_data,
    output logic [SEQ_W-1:0]  out_seq,
    output logic              out_err,
    output logic              proto_err,
    output logic              ovf
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] H1_LIM = CNT_W'(HALT1_TH);
    localparam logic [CNT_W-1:0] H2_LIM = CNT_W'(HALT2_TH);

    seq_state_t       state_q, state_d;
    logic [SEQ_W-1:0] next_seq_q, next_seq_d, tlp_seq;
    logic             want_wr, wr, rd, viol, abandon, ent_err;
    seq_entry_t       wr_ent, head;
    logic [CNT_W-1:0] count, free, free_post;
    logic             full;

    always_comb begin
        state_d = state_q;
        want_wr = 1'b0;
        viol    = 1'b0;
        abandon = 1'b0;
        if (in_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (in_sop) begin
                        want_wr = 1'b1;
                        state_d = in_eop ? ST_IDLE : ST_IN_TLP;
                    end else begin
                        viol = 1'b1;
                    end
                end
                ST_IN_TLP: begin
                    want_wr = 1'b1;
                    // A sop here abandons the open TLP, which still consumes its number.
                    if (in_sop) begin
                        viol    = 1'b1;
                        abandon = 1'b1;
                    end
                    if (in_eop) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign rd         = out_valid & out_ready;
    assign wr         = want_wr & (~full | rd);
    assign tlp_seq    = next_seq_q + SEQ_W'(abandon);
    assign next_seq_d = tlp_seq + SEQ_W'(wr & in_eop);
    assign free_post  = free - CNT_W'(wr) + CNT_W'(rd);

`ifdef DLL_TX_LEN_CHECK_EN
    localparam int DWC_W = LEN_W + 1;
    logic [DWC_W-1:0] dw_cnt_q, dw_sum, len_cmp;
    logic [LEN_W-1:0] len_q;

    always_comb begin
        dw_sum  = (in_sop ? '0 : dw_cnt_q) + DWC_W'(in_vdw) + DWC_W'(1);
        len_cmp = {1'b0, (in_sop ? in_len : len_q)};
        ent_err = in_eop & (dw_sum != len_cmp);
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            dw_cnt_q <= '0;
            len_q    <= '0;
        end else if (want_wr) begin
            dw_cnt_q <= in_eop ? '0 : dw_sum;
            if (in_sop) len_q <= in_len;
        end
    end
`else
    logic unused_len;
    assign unused_len = ^in_len;
    assign ent_err    = 1'b0;
`endif

    always_comb begin
        wr_ent      = '0;
        wr_ent.sop  = in_sop;
        wr_ent.eop  = in_eop;
        wr_ent.err  = ent_err;
        wr_ent.vdw  = in_vdw;
        wr_ent.seq  = tlp_seq;
        wr_ent.data = in_data;
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q    <= ST_IDLE;
            next_seq_q <= '0;
            proto_err  <= 1'b0;
            ovf        <= 1'b0;
            halt_1     <= 1'b0;
            halt_2     <= 1'b0;
        end else begin
            state_q    <= state_d;
            next_seq_q <= next_seq_d;
            proto_err  <= viol;
            ovf        <= ovf | (want_wr & full & ~rd);
            halt_1     <= (free_post < H1_LIM);
            halt_2     <= (free_post < H2_LIM);
        end
    end

    dll_tx_seq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .arst   (arst),
        .wr     (wr),
        .wr_ent (wr_ent),
        .rd     (rd),
        .head   (head),
        .count  (count),
        .free   (free),
        .full   (full)
    );

    assign out_valid = (count != '0);
    assign out_sop   = head.sop;
    assign out_eop   = head.eop;
    assign out_vdw   = head.vdw;
    assign out_data  = head.data;
    assign out_seq   = head.seq;
    assign out_err   = head.err;

endmodule

// File: tb/tb_dll_tx_tlp_sequencer.sv
// Directed bench for dll_tx_tlp_sequencer; expected out_err follows DLL_TX_LEN_CHECK_EN.
module tb_dll_tx_tlp_sequencer;

    logic         clk;
    logic         arst;
    logic         in_valid, in_sop, in_eop;
    logic [10:0]  in_len;
    logic [2:0]   in_vdw;
    logic [255:0] in_data;
    logic         halt_1, halt_2, out_valid, out_ready, out_sop, out_eop;
    logic [2:0]   out_vdw;
    logic [255:0] out_data;
    logic [11:0]  out_seq;
    logic         out_err, proto_err, ovf;

    int n_assert = 0;
    int n_fail   = 0;
    logic exp_len_err;

    dll_tx_tlp_sequencer dut (
        .clk       (clk),
        .arst      (arst),
        .in_valid  (in_valid),
        .in_sop    (in_sop),
        .in_eop    (in_eop),
        .in_len    (in_len),
        .in_vdw    (in_vdw),
        .in_data   (in_data),
        .halt_1    (halt_1),
        .halt_2    (halt_2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .out_vdw   (out_vdw),
        .out_data  (out_data),
        .out_seq   (out_seq),
        .out_err   (out_err),
        .proto_err (proto_err),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk_s(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic sop, input logic eop, input logic [2:0] vdw,
                        input logic [10:0] len, input logic [255:0] data);
        in_valid = 1'b1;
        in_sop   = sop;
        in_eop   = eop;
        in_vdw   = vdw;
        in_len   = len;
        in_data  = data;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    task automatic pop();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
`ifdef DLL_TX_LEN_CHECK_EN
        exp_len_err = 1'b1;
`else
        exp_len_err = 1'b0;
`endif
        arst = 1'b0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        in_len = '0; in_vdw = '0; in_data = '0; out_ready = 1'b0;
        repeat (3) idle();
        chk_b("rst_out_valid", out_valid, 1'b0);
        chk_b("rst_halt_1", halt_1, 1'b0);
        chk_b("rst_halt_2", halt_2, 1'b0);
        chk_b("rst_ovf", ovf, 1'b0);
        chk_b("rst_proto_err", proto_err, 1'b0);
        chk_w("rst_out_data", out_data, 256'h0);
        arst = 1'b1;
        idle();

        // 3DW MWr with ECRC: 11 DW over two beats, seq 0
        beat(1'b1, 1'b0, 3'd7, 11'd11, 256'hA1);
        chk_b("t1_valid_latency", out_valid, 1'b1);
        beat(1'b0, 1'b1, 3'd2, 11'd0, 256'hA2);
        chk_b("t1_sop", out_sop, 1'b1);
        chk_b("t1_eop0", out_eop, 1'b0);
        chk_s("t1_seq0", out_seq, 12'd0);
        chk_s("t1_vdw0", {9'd0, out_vdw}, 12'd7);
        chk_w("t1_data0", out_data, 256'hA1);
        pop();
        chk_b("t1_eop1", out_eop, 1'b1);
        chk_s("t1_seq1", out_seq, 12'd0);
        chk_b("t1_err", out_err, 1'b0);
        chk_w("t1_data1", out_data, 256'hA2);
        pop();
        chk_b("t1_empty", out_valid, 1'b0);

        // Same TLP advertising 12 DW: length mismatch, seq 1
        beat(1'b1, 1'b0, 3'd7, 11'd12, 256'hB1);
        beat(1'b0, 1'b1, 3'd2, 11'd0, 256'hB2);
        chk_s("t2_seq0", out_seq, 12'd1);
        chk_b("t2_err_sop", out_err, 1'b0);
        pop();
        chk_b("t2_err_eop", out_err, exp_len_err);
        pop();
        beat(1'b1, 1'b1, 3'd3, 11'd4, 256'hC1);
        chk_s("t2_next_seq", out_seq, 12'd2);
        chk_b("t2_single_err", out_err, 1'b0);
        pop();

        // Protocol violations
        beat(1'b0, 1'b0, 3'd7, 11'd0, 256'hD0);
        chk_b("t3_idle_proto", proto_err, 1'b1);
        chk_b("t3_idle_drop", out_valid, 1'b0);
        idle();
        chk_b("t3_proto_pulse", proto_err, 1'b0);
        beat(1'b1, 1'b0, 3'd7, 11'd16, 256'hD1);
        chk_b("t3_no_proto", proto_err, 1'b0);
        beat(1'b1, 1'b0, 3'd7, 11'd16, 256'hD2);
        chk_b("t3_sop_proto", proto_err, 1'b1);
        beat(1'b0, 1'b1, 3'd7, 11'd0, 256'hD3);
        chk_b("t3_proto_clear", proto_err, 1'b0);
        chk_s("t3_abandoned_seq", out_seq, 12'd3);
        pop();
        chk_s("t3_new_seq", out_seq, 12'd4);
        chk_b("t3_new_sop", out_sop, 1'b1);
        pop();
        chk_s("t3_new_eop_seq", out_seq, 12'd4);
        chk_b("t3_new_eop", out_eop, 1'b1);
        chk_b("t3_new_err", out_err, 1'b0);
        pop();

        // Fill with single-beat TLPs seq 5..12 and watch the halts
        for (int i = 0; i < 8; i++) begin
            beat(1'b1, 1'b1, 3'd0, 11'd1, 256'(i));
            chk_b("t4_halt_1", halt_1, i >= 4);
            chk_b("t4_halt_2", halt_2, i >= 6);
        end
        chk_b("t4_full_no_ovf", ovf, 1'b0);
        beat(1'b1, 1'b1, 3'd0, 11'd1, 256'h99);
        chk_b("t4_ovf", ovf, 1'b1);
        out_ready = 1'b1;
        beat(1'b1, 1'b1, 3'd0, 11'd1, 256'h13);
        chk_s("t4_simul_head", out_seq, 12'd6);
        chk_b("t4_simul_halt_2", halt_2, 1'b1);
        chk_b("t4_simul_ovf", ovf, 1'b1);
        for (int i = 0; i < 8; i++) begin
            chk_s("t4_drain_seq", out_seq, 12'(6 + i));
            idle();
        end
        out_ready = 1'b0;
        chk_b("t4_drained", out_valid, 1'b0);
        chk_b("t4_drain_halt_1", halt_1, 1'b0);
        chk_b("t4_ovf_sticky", ovf, 1'b1);

        // Advance next_seq from 14 to 4095 with the FIFO streaming
        out_ready = 1'b1;
        for (int i = 0; i < 4081; i++) beat(1'b1, 1'b1, 3'd0, 11'd1, 256'(i));
        idle();
        out_ready = 1'b0;
        chk_b("t5_streamed", out_valid, 1'b0);
        beat(1'b1, 1'b1, 3'd0, 11'd1, 256'hE1);
        beat(1'b1, 1'b1, 3'd0, 11'd1, 256'hE2);
        chk_s("t5_seq_4095", out_seq, 12'd4095);
        pop();
        chk_s("t5_seq_wrap", out_seq, 12'd0);
        chk_w("t5_wrap_data", out_data, 256'hE2);

        // Reset with three entries queued and a TLP open
        beat(1'b1, 1'b1, 3'd0, 11'd1, 256'hF1);
        beat(1'b1, 1'b0, 3'd7, 11'd16, 256'hF2);
        chk_b("t6_pre_valid", out_valid, 1'b1);
        arst = 1'b0;
        #2;
        chk_b("t6_rst_valid", out_valid, 1'b0);
        chk_b("t6_rst_halt_1", halt_1, 1'b0);
        chk_b("t6_rst_halt_2", halt_2, 1'b0);
        chk_b("t6_rst_ovf", ovf, 1'b0);
        #2;
        arst = 1'b1;
        idle();
        beat(1'b1, 1'b1, 3'd3, 11'd4, 256'hF3);
        chk_b("t6_post_proto", proto_err, 1'b0);
        chk_s("t6_post_seq", out_seq, 12'd0);
        chk_b("t6_post_sop", out_sop, 1'b1);
        chk_w("t6_post_data", out_data, 256'hF3);
        pop();
        chk_b("t6_post_empty", out_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
